tick_period_monitor: RTL and testbench

- Receive-side checker for the slow divided-clock / LED tick produced by the clock-divider blocks (e.g. the 1 Hz LED toggle).
- Synchronises the tick into the system clock domain and measures its period and high time in `clk` cycles.
- Checks each period against an expected value with a tolerance and reports lock and timeout.
- Sits beside a divider as a self-check, or in a board design to drive status LEDs.

---
 rtl/tick_period_monitor_if.sv | 27 ++
 rtl/tick_period_monitor.sv | 172 +++++++++++++++++
 tb/tb_tick_period_monitor.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/tick_period_monitor_if.sv
// Result bundle of the tick period monitor: monitored tick plus measurement outputs.
// With TICK_MON_HIGH_TIME_EN defined the bundle also carries high_time.
`timescale 1ns/1ps
interface tick_period_monitor_if #(
    parameter int unsigned CNT_W = 32
);
    logic             tick_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             in_range;
    logic             locked;
    logic             timeout;
    logic [15:0]      edge_cnt;
`ifdef TICK_MON_HIGH_TIME_EN
    logic [CNT_W-1:0] high_time;

    modport master (input tick_in, output period, period_valid, in_range, locked,
                    timeout, edge_cnt, high_time);
    modport slave  (output tick_in, input period, period_valid, in_range, locked,
                    timeout, edge_cnt, high_time);
`else
    modport master (input tick_in, output period, period_valid, in_range, locked,
                    timeout, edge_cnt);
    modport slave  (output tick_in, input period, period_valid, in_range, locked,
                    timeout, edge_cnt);
`endif
endinterface

// File: rtl/tick_period_monitor.sv
// Measures period/high time of a slow asynchronous tick and reports range, lock and timeout.
// Optional high-time measurement is enabled by defining TICK_MON_HIGH_TIME_EN.
`timescale 1ns/1ps
module tick_period_monitor #(
    parameter int unsigned EXP_PERIOD = 100000000,
    parameter int unsigned TOL        = 1000,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned CNT_W      = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    tick_period_monitor_if.master mon
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STALLED = 2'd2;

    localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]        TMO_LIM  = CNT_W'(2 * EXP_PERIOD);
    localparam logic signed [CNT_W:0]   EXP_S    = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]          TOL_U    = (CNT_W+1)'(TOL);
    localparam logic [3:0]              LOCK_TGT = 4'(LOCK_CNT);

    logic             s1, s2, s3, rise_q;
    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       lock_ctr, lock_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             in_range_q, in_range_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             valid_q, valid_d;
    logic [15:0]      edge_q, edge_d;

    logic signed [CNT_W:0] diff_c;
    logic [CNT_W:0]        mag_c;
    logic                  in_range_c;

`ifdef TICK_MON_HIGH_TIME_EN
    logic             fall_q;
    logic [CNT_W-1:0] hcnt, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
`endif

    // Synchroniser, edge-detect flop and registered edge flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            rise_q <= 1'b0;
`ifdef TICK_MON_HIGH_TIME_EN
            fall_q <= 1'b0;
`endif
        end else begin
            s1     <= mon.tick_in;
            s2     <= s1;
            s3     <= s2;
            rise_q <= s2 & ~s3;
`ifdef TICK_MON_HIGH_TIME_EN
            fall_q <= ~s2 & s3;
`endif
        end
    end

    // Range check on the period about to be published (cnt at the rise)
    always_comb begin
        diff_c     = $signed({1'b0, cnt}) - EXP_S;
        mag_c      = diff_c[CNT_W] ? $unsigned(-diff_c) : $unsigned(diff_c);
        in_range_c = (mag_c <= TOL_U);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        cnt_d      = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        lock_d     = lock_ctr;
        period_d   = period_q;
        in_range_d = in_range_q;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
        valid_d    = 1'b0;
        edge_d     = edge_q + 16'(rise_q);
        if (rise_q) cnt_d = CNT_W'(1);

        case (state)
            ST_IDLE: begin
                if (rise_q) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (rise_q) begin
                    period_d   = cnt;
                    in_range_d = in_range_c;
                    valid_d    = 1'b1;
                    if (in_range_c)
                        lock_d = (lock_ctr == LOCK_TGT) ? lock_ctr : lock_ctr + 4'd1;
                    else
                        lock_d = 4'd0;
                    locked_d = (lock_d == LOCK_TGT);
                end else if (cnt == TMO_LIM) begin
                    state_d   = ST_STALLED;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    lock_d    = 4'd0;
                end
            end
            ST_STALLED: begin
                // Interval spanning the stall is meaningless, so nothing is published
                if (rise_q) begin
                    timeout_d = 1'b0;
                    state_d   = ST_MEASURE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef TICK_MON_HIGH_TIME_EN
    // High-time counter tracks the level aligned with the registered edge flags
    always_comb begin
        hcnt_d = hcnt;
        high_d = high_q;
        if (rise_q)                     hcnt_d = CNT_W'(1);
        else if (s3 && hcnt != CNT_MAX) hcnt_d = hcnt + CNT_W'(1);
        if (fall_q && state == ST_MEASURE) high_d = hcnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= '0;
            high_q <= '0;
        end else begin
            hcnt   <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign mon.high_time = high_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lock_ctr   <= 4'd0;
            period_q   <= '0;
            in_range_q <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
            valid_q    <= 1'b0;
            edge_q     <= 16'd0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            lock_ctr   <= lock_d;
            period_q   <= period_d;
            in_range_q <= in_range_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
            valid_q    <= valid_d;
            edge_q     <= edge_d;
        end
    end

    assign mon.period       = period_q;
    assign mon.period_valid = valid_q;
    assign mon.in_range     = in_range_q;
    assign mon.locked       = locked_q;
    assign mon.timeout      = timeout_q;
    assign mon.edge_cnt     = edge_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed + randomized bench for tick_period_monitor against an interval-based reference model.
`timescale 1ns/1ps
module tb_tick_period_monitor;
    localparam int EXP = 20;
    localparam int TOL = 2;
    localparam int LCK = 3;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tick_period_monitor_if #(.CNT_W(CW)) bus ();

    tick_period_monitor #(
        .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LCK), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mon(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pv_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.period_valid === 1'b1) pv_seen <= pv_seen + 1;

    // Reference model: everything follows from the spacing between driven rises
    bit armed;
    int last_rise, lk, m_period, m_inr, m_locked, m_edges, m_pubs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        armed = 0; last_rise = 0; lk = 0;
        m_period = 0; m_inr = 0; m_locked = 0; m_edges = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period"}, 32'(bus.period), 0);
        chk({tag, "_valid"}, 32'(bus.period_valid), 0);
        chk({tag, "_in_range"}, 32'(bus.in_range), 0);
        chk({tag, "_locked"}, 32'(bus.locked), 0);
        chk({tag, "_timeout"}, 32'(bus.timeout), 0);
        chk({tag, "_edge_cnt"}, 32'(bus.edge_cnt), 0);
`ifdef TICK_MON_HIGH_TIME_EN
        chk({tag, "_high_time"}, 32'(bus.high_time), 0);
`endif
    endtask

    // One tick: high for h cycles, low for p-h (needs h>=5, p-h>=4); called at posedge+1
    task automatic pulse(input int p, input int h);
        int rise_at, gap, d;
        bit pub;
        bus.tick_in = 1'b1;
        rise_at = cyc + 1;
        gap = rise_at - last_rise;
        m_edges = (m_edges + 1) % 65536;
        pub = armed && (gap <= 2 * EXP);
        if (pub) begin
            m_period = gap;
            d = gap - EXP;
            if (d < 0) d = -d;
            m_inr = (d <= TOL) ? 1 : 0;
            if (m_inr == 1) lk = (lk < LCK) ? lk + 1 : lk;
            else lk = 0;
            m_pubs++;
        end else if (armed) begin
            lk = 0;
        end
        m_locked = (lk == LCK) ? 1 : 0;
        armed = 1;
        last_rise = rise_at;

        wait_edges(3);
        chk("valid_early", 32'(bus.period_valid), 0);
        wait_edges(1);
        chk("valid", 32'(bus.period_valid), 32'(pub));
        chk("period", 32'(bus.period), 32'(m_period));
        chk("in_range", 32'(bus.in_range), 32'(m_inr));
        chk("locked", 32'(bus.locked), 32'(m_locked));
        chk("timeout_at_rise", 32'(bus.timeout), 0);
        chk("edge_cnt", 32'(bus.edge_cnt), 32'(m_edges));
        wait_edges(h - 4);
        chk("valid_pulses", 32'(pv_seen), 32'(m_pubs));
        bus.tick_in = 1'b0;
        wait_edges(p - h);
`ifdef TICK_MON_HIGH_TIME_EN
        chk("high_time", 32'(bus.high_time), 32'(h));
`endif
    endtask

    initial begin
        int p, h;
        model_reset();
        m_pubs = 0;
        bus.tick_in = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        wait_edges(3);
        rst_n = 1'b1;

        // Idle with no tick: everything stays 0, no timeout from IDLE
        wait_edges(100);
        check_all_zero("idle");

        // Nominal square wave: lock after three in-range publishes
        for (int i = 0; i < 5; i++) pulse(20, 10);

        // One out-of-range period, then relock
        pulse(23, 10);
        for (int i = 0; i < 4; i++) pulse(20, 10);

        // Tolerance boundaries 18/22 in range, 17 out
        pulse(18, 9);
        pulse(22, 11);
        pulse(17, 8);
        for (int i = 0; i < 4; i++) pulse(20, 10);

        // Timeout exactly 2*EXP cycles after the last rise detection
        wait_edges(last_rise + 42 - cyc);
        chk("timeout_before", 32'(bus.timeout), 0);
        chk("locked_before_tmo", 32'(bus.locked), 1);
        wait_edges(1);
        chk("timeout_set", 32'(bus.timeout), 1);
        chk("locked_after_tmo", 32'(bus.locked), 0);
        chk("period_held", 32'(bus.period), 32'(m_period));
        wait_edges(15);
        chk("timeout_sticky", 32'(bus.timeout), 1);
        for (int i = 0; i < 4; i++) pulse(20, 10);

        // Rise coinciding with the timeout threshold wins; one cycle later it does not
        pulse(20, 10);
        pulse(40, 10);
        pulse(41, 10);
        pulse(20, 10);
        pulse(20, 10);

        // Randomized periods, mostly near nominal, occasionally far or stalled
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) p = int'($urandom_range(9, 46));
            else p = int'($urandom_range(17, 23));
            h = int'($urandom_range(5, 32'(p - 4)));
            pulse(p, h);
        end

        // Asynchronous reset while locked, mid-measurement
        for (int i = 0; i < 4; i++) pulse(20, 10);
        chk("locked_pre_reset", 32'(bus.locked), 1);
        wait_edges(5);
        rst_n = 1'b0;
        #0.4;
        check_all_zero("async_rst");
        #0.6;
        rst_n = 1'b1;
        model_reset();
        wait_edges(10);
        for (int i = 0; i < 5; i++) pulse(20, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
